// File: rtl/line_drawer2.sv
// rtl/line_drawer2.sv - Bresenham line / full-screen clear rasteriser, one pixel per clock.
module line_drawer2 #(
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] x0,
  input  logic [10:0] y0,
  input  logic [10:0] x1,
  input  logic [10:0] y1,
  input  logic        start,
  input  logic        clear,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        colour,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LINE  = 2'd1,
    S_CLEAR = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [10:0] LP_XMAX = 11'(SCREEN_W - 1);
  localparam logic [10:0] LP_YMAX = 11'(SCREEN_H - 1);

  state_t r_state;
  state_t w_next;

  // Line walk state; r_xcur/r_ycur double as the clear sweep counters.
  logic               r_steep;
  logic               r_yup;
  logic [10:0]        r_xcur;
  logic [10:0]        r_ycur;
  logic [10:0]        r_xb;
  logic [10:0]        r_dx;
  logic [10:0]        r_dy;
  logic signed [12:0] r_err;

  // Last emitted pixel, replayed in DONE and IDLE.
  logic [10:0]        r_lx;
  logic [10:0]        r_ly;
  logic               r_lc;

  logic [10:0]        w_adx;
  logic [10:0]        w_ady;
  logic               w_steep;
  logic [10:0]        w_p0x;
  logic [10:0]        w_p0y;
  logic [10:0]        w_p1x;
  logic [10:0]        w_p1y;
  logic               w_swap;
  logic [10:0]        w_xa;
  logic [10:0]        w_ya;
  logic [10:0]        w_xb;
  logic [10:0]        w_yb;
  logic [10:0]        w_dx;
  logic [10:0]        w_dy;
  logic signed [12:0] w_err0;

  logic signed [12:0] w_err_acc;
  logic               w_take;
  logic signed [12:0] w_err_nxt;
  logic [10:0]        w_ycur_nxt;
  logic               w_line_last;
  logic               w_clr_xend;
  logic               w_clr_last;

  // Setup arithmetic evaluated from the live inputs, captured on the start edge.
  assign w_adx   = (x1 >= x0) ? (x1 - x0) : (x0 - x1);
  assign w_ady   = (y1 >= y0) ? (y1 - y0) : (y0 - y1);
  assign w_steep = (w_ady > w_adx);
  assign w_p0x   = w_steep ? y0 : x0;
  assign w_p0y   = w_steep ? x0 : y0;
  assign w_p1x   = w_steep ? y1 : x1;
  assign w_p1y   = w_steep ? x1 : y1;
  assign w_swap  = (w_p0x > w_p1x);
  assign w_xa    = w_swap ? w_p1x : w_p0x;
  assign w_ya    = w_swap ? w_p1y : w_p0y;
  assign w_xb    = w_swap ? w_p0x : w_p1x;
  assign w_yb    = w_swap ? w_p0y : w_p1y;
  assign w_dx    = w_xb - w_xa;
  assign w_dy    = (w_yb >= w_ya) ? (w_yb - w_ya) : (w_ya - w_yb);
  assign w_err0  = 13'sd0 - $signed({3'b000, w_dx[10:1]});

  assign w_err_acc   = r_err + $signed({2'b00, r_dy});
  assign w_take      = ~w_err_acc[12];
  assign w_err_nxt   = w_take ? (w_err_acc - $signed({2'b00, r_dx})) : w_err_acc;
  assign w_ycur_nxt  = w_take ? (r_yup ? (r_ycur + 11'd1) : (r_ycur - 11'd1)) : r_ycur;
  assign w_line_last = (r_xcur == r_xb);
  assign w_clr_xend  = (r_xcur == LP_XMAX);
  assign w_clr_last  = w_clr_xend && (r_ycur == LP_YMAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = clear ? S_CLEAR : S_LINE;
        end
      end
      S_LINE: begin
        if (w_line_last) begin
          w_next = S_DONE;
        end
      end
      S_CLEAR: begin
        if (w_clr_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        if (!start) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    x      = r_lx;
    y      = r_ly;
    colour = r_lc;
    done   = 1'b0;
    case (r_state)
      S_LINE: begin
        x      = r_steep ? r_ycur : r_xcur;
        y      = r_steep ? r_xcur : r_ycur;
        colour = 1'b1;
      end
      S_CLEAR: begin
        x      = r_xcur;
        y      = r_ycur;
        colour = 1'b0;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_steep <= 1'b0;
      r_yup   <= 1'b0;
      r_xcur  <= '0;
      r_ycur  <= '0;
      r_xb    <= '0;
      r_dx    <= '0;
      r_dy    <= '0;
      r_err   <= '0;
      r_lx    <= '0;
      r_ly    <= '0;
      r_lc    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && clear) begin
            r_xcur <= '0;
            r_ycur <= '0;
          end else if (start) begin
            r_steep <= w_steep;
            r_yup   <= (w_ya < w_yb);
            r_xcur  <= w_xa;
            r_ycur  <= w_ya;
            r_xb    <= w_xb;
            r_dx    <= w_dx;
            r_dy    <= w_dy;
            r_err   <= w_err0;
          end
        end
        S_LINE: begin
          r_lx   <= x;
          r_ly   <= y;
          r_lc   <= colour;
          r_err  <= w_err_nxt;
          r_ycur <= w_ycur_nxt;
          r_xcur <= r_xcur + 11'd1;
        end
        S_CLEAR: begin
          r_lx <= x;
          r_ly <= y;
          r_lc <= colour;
          if (w_clr_xend) begin
            r_xcur <= '0;
            r_ycur <= r_ycur + 11'd1;
          end else begin
            r_xcur <= r_xcur + 11'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_line_drawer2.sv
// tb/tb_line_drawer2.sv - self-checking bench for line_drawer2 against a reference pixel-list model.
module tb_line_drawer2;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] x0, y0, x1, y1;
  logic        start, clear;
  logic [10:0] x, y;
  logic        colour, done;

  line_drawer2 #(.SCREEN_W(320), .SCREEN_H(240)) dut (
    .clk(clk), .reset(reset),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .start(start), .clear(clear),
    .x(x), .y(y), .colour(colour), .done(done)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int n_printed = 0;

  int qx[$];
  int qy[$];
  int qc[$];

  bit mon_active = 1'b0;
  int mon_pix;
  int fx, fy, lx, ly;
  int min_x, max_x, prev_y;
  bit mono;

  function automatic void check(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference: textbook Bresenham over plain integers, producing the ordered pixel list.
  function automatic void model_line(int ax, int ay, int bx, int by);
    int t, dx, dy, err, ys, yc;
    bit steep;
    steep = iabs(by - ay) > iabs(bx - ax);
    if (steep) begin
      t = ax; ax = ay; ay = t;
      t = bx; bx = by; by = t;
    end
    if (ax > bx) begin
      t = ax; ax = bx; bx = t;
      t = ay; ay = by; by = t;
    end
    dx  = bx - ax;
    dy  = iabs(by - ay);
    err = -(dx / 2);
    ys  = (ay < by) ? 1 : -1;
    yc  = ay;
    for (int xc = ax; xc <= bx; xc++) begin
      qx.push_back(steep ? yc : xc);
      qy.push_back(steep ? xc : yc);
      qc.push_back(1);
      err += dy;
      if (err >= 0) begin
        yc  += ys;
        err -= dx;
      end
    end
  endfunction

  function automatic void model_clear();
    for (int cy = 0; cy < 240; cy++)
      for (int cx = 0; cx < 320; cx++) begin
        qx.push_back(cx);
        qy.push_back(cy);
        qc.push_back(0);
      end
  endfunction

  // Single compare process: every pixel cycle, then the done cycle that follows.
  always @(negedge clk) begin
    if (mon_active) begin
      if (qx.size() > 0) begin
        int ex, ey, ec;
        ex = qx.pop_front();
        ey = qy.pop_front();
        ec = qc.pop_front();
        n_total++;
        if (x == ex && y == ey && colour == ec && done == 1'b0) begin
          n_pass++;
        end else begin
          if (n_printed < 20)
            $display("FAIL pixel[%0d]: got x=%0d y=%0d c=%0d done=%0d expected x=%0d y=%0d c=%0d done=0",
                     mon_pix, x, y, colour, done, ex, ey, ec);
          n_printed++;
        end
        if (mon_pix == 0) begin
          fx = x;
          fy = y;
        end else if (int'(y) < prev_y) begin
          mono = 1'b0;
        end
        lx = x;
        ly = y;
        prev_y = y;
        if (int'(x) < min_x) min_x = x;
        if (int'(x) > max_x) max_x = x;
        mon_pix++;
      end else begin
        check("done_rise", done, 1);
        mon_active = 1'b0;
      end
    end
  end

  task automatic run_op(input int ax, input int ay, input int bx, input int by,
                        input bit clr, input int exp_n);
    int ex_l, ey_l, ec_l, cyc;
    qx.delete(); qy.delete(); qc.delete();
    if (clr) model_clear();
    else model_line(ax, ay, bx, by);
    check("model_count", qx.size(), exp_n);
    ex_l = qx[qx.size() - 1];
    ey_l = qy[qy.size() - 1];
    ec_l = qc[qc.size() - 1];
    @(negedge clk);
    #1;
    x0 = 11'(ax); y0 = 11'(ay); x1 = 11'(bx); y1 = 11'(by);
    clear = clr;
    start = 1'b1;
    mon_pix = 0; min_x = 99999; max_x = -1; mono = 1'b1; prev_y = 0;
    mon_active = 1'b1;
    // Inputs wander after the latch edge; they must be ignored.
    @(negedge clk);
    #2;
    x0 = 11'd3; y0 = 11'd4; x1 = 11'd5; y1 = 11'd6; clear = ~clr;
    cyc = 0;
    while (mon_active && cyc < exp_n + 10) begin
      @(negedge clk);
      #2;
      cyc++;
    end
    if (mon_active) begin
      check("op_timeout", 1, 0);
      mon_active = 1'b0;
    end
    repeat (3) begin
      @(negedge clk);
      #2;
      check("done_held", done, 1);
    end
    check("hold_x", x, ex_l);
    check("hold_y", y, ey_l);
    check("hold_c", colour, ec_l);
    start = 1'b0;
    @(negedge clk);
    #2;
    check("done_fall", done, 0);
    check("idle_x", x, ex_l);
    check("idle_y", y, ey_l);
    if (!clr)
      check("endpoints",
            ((fx == ax && fy == ay && lx == bx && ly == by) ||
             (fx == bx && fy == by && lx == ax && ly == ay)) ? 1 : 0, 1);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    clear = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    repeat (2) @(negedge clk);
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_c", colour, 0);
    check("rst_done", done, 0);
    #2 reset = 1'b0;

    run_op(50, 50, 50, 150, 1'b0, 101);
    check("vert_minx", min_x, 50);
    check("vert_maxx", max_x, 50);
    check("vert_first_y", fy, 50);
    check("vert_last_y", ly, 150);

    run_op(50, 50, 150, 50, 1'b0, 101);
    check("horiz_mono", mono, 1);
    check("horiz_last_x", lx, 150);

    run_op(0, 0, 319, 239, 1'b0, 320);
    check("diag_mono", mono, 1);
    check("diag_last_x", lx, 319);
    check("diag_last_y", ly, 239);

    run_op(150, 2047, 0, 2047, 1'b1, 76800);
    check("clear_pixels", mon_pix, 76800);
    check("clear_last_x", lx, 319);
    check("clear_last_y", ly, 239);

    run_op(0, 100, 319, 90, 1'b0, 320);
    run_op(0, 100, 20, 0, 1'b0, 101);
    run_op(100, 100, 0, 0, 1'b0, 101);
    check("diag_rev_first_x", fx, 0);
    run_op(200, 100, 0, 101, 1'b0, 201);
    run_op(200, 100, 0, 210, 1'b0, 201);
    run_op(200, 10, 199, 210, 1'b0, 201);
    check("steep_minx", min_x, 199);
    check("steep_maxx", max_x, 200);

    // Reset 20 cycles into a diagonal line.
    @(negedge clk);
    #1;
    x0 = 11'd0; y0 = 11'd0; x1 = 11'd319; y1 = 11'd239; clear = 1'b0; start = 1'b1;
    repeat (20) @(negedge clk);
    #2;
    check("midline_busy", done, 0);
    reset = 1'b1;
    #1;
    check("arst_x", x, 0);
    check("arst_y", y, 0);
    check("arst_c", colour, 0);
    check("arst_done", done, 0);
    start = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    #2;
    check("post_rst_x", x, 0);
    check("post_rst_done", done, 0);

    run_op(7, 9, 7, 9, 1'b0, 1);
    check("point_x", fx, 7);
    check("point_y", fy, 9);
    run_op(319, 239, 0, 0, 1'b0, 320);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/line_drawer2.md
Name: line_drawer2

Overview:
- Sequential rasteriser that emits one pixel per clock on (x, y, colour) for a VGA/framebuffer writer.
- Line mode draws a Bresenham line from (x0,y0) to (x1,y1), inclusive of both endpoints, with colour=1.
- Clear mode sweeps every pixel of a 320x240 screen with colour=0.
- Sits between the drawing controller, which drives start/clear/endpoints, and the framebuffer write port.

Parameters:
- SCREEN_W, 320, number of columns swept in clear mode (x = 0..SCREEN_W-1).
- SCREEN_H, 240, number of rows swept in clear mode (y = 0..SCREEN_H-1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- x0  input  11  line start x, unsigned.
- y0  input  11  line start y, unsigned.
- x1  input  11  line end x, unsigned.
- y1  input  11  line end y, unsigned.
- start  input  1  level request; held high until done is seen.
- clear  input  1  selects clear mode when sampled with start; endpoints are ignored.
- x  output  11  current pixel x.
- y  output  11  current pixel y.
- colour  output  1  current pixel colour: 1 = line, 0 = clear.
- done  output  1  operation complete; handshake acknowledge.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, x=0, y=0, colour=0, done=0; any operation in progress is abandoned.
- States: IDLE, LINE, CLEAR, DONE.
- IDLE:
  - done=0.
  - On a clk edge with start=1: clear=1 goes to CLEAR; clear=0 goes to LINE.
  - Inputs are sampled and latched on that edge; later changes to inputs have no effect until the next IDLE.
- Line setup, done in the latching edge:
  - steep = |y1-y0| > |x1-x0|. If steep, swap x/y of both endpoints.
  - If the (possibly swapped) xa > xb, swap the endpoints.
  - dx = xb-xa; dy = |yb-ya|; ystep = +1 if ya<yb else -1.
  - error = -(dx/2), where dx/2 is an arithmetic shift right.
  - Deltas are 12-bit signed; error is 13-bit signed. There is no overflow for 11-bit inputs.
- LINE, one pixel per cycle:
  - Output (x,y) = steep ? (ycur,xcur) : (xcur,ycur), with colour=1.
  - Then error += dy; if error >= 0 then ycur += ystep and error -= dx; xcur += 1.
  - The pixel with xcur==xb is the last one. The next state is DONE.
  - Pixel count = max(|dx|,|dy|)+1. Identical endpoints give exactly 1 pixel.
- First pixel appears on outputs the cycle after start is sampled. done rises the cycle after the last pixel is presented.
- CLEAR:
  - Presents (cx,cy) with colour=0, starting at (0,0).
  - cx increments each cycle. At SCREEN_W-1, cx wraps to 0 and cy increments.
  - After (SCREEN_W-1, SCREEN_H-1) the next state is DONE; total 76800 pixels.
- DONE:
  - done=1, held while start=1.
  - x, y and colour hold the last emitted pixel, so repeated writes are idempotent.
  - When start=0 the next state is IDLE and done falls the following cycle.
- IDLE outputs: x, y and colour keep their last values (0,0,0 after reset).
- No clipping: coordinates are drawn as given within the 11-bit range.
- start=0 during LINE/CLEAR is ignored; the operation runs to completion.
- clear changing mid-operation is ignored.
- Downstream write enable: a pixel is valid every cycle in LINE/CLEAR. DONE/IDLE repeat a pixel that was already written, so writes during them are harmless.

Test Plan:
- Vertical line (50,50)->(50,150) -> x=50 on every pixel, y sweeps 50..150 (101 pixels, colour=1); done within 103 cycles of start; done stays high until start drops, then IDLE.
- Horizontal line (50,50)->(150,50), then diagonal (0,0)->(319,239) -> 101 and 320 pixels respectively; endpoints hit exactly; y monotonic non-decreasing.
- Clear with x0=150, x1=0, y0=y1=2047 -> endpoints ignored; 76800 pixels with colour=0, raster order (0,0),(1,0)…(319,239); done afterwards.
- Reverse/steep lines:
  - (0,100)->(319,90): 320 pixels.
  - (0,100)->(20,0): 101 pixels, steep.
  - (100,100)->(0,0): 101 pixels on x==y.
  - (200,100)->(0,101) and (200,100)->(0,210): 201 pixels each.
  - (200,10)->(199,210): 201 pixels, x only 199..200.
  - Every line includes both endpoints.
- Reset asserted mid-line (e.g. 20 cycles into the (0,0)->(319,239) line) -> outputs go to x=0, y=0, colour=0, done=0 immediately (asynchronous); the next start draws a fresh line correctly.
- Single-point line (7,9)->(7,9) -> exactly one pixel (7,9), colour=1; done the following cycle.
